mem_wb_stage: RTL and testbench

Pipelined memory stage plus MEM/WB register for the 16-bit CPU. Sits between the execute stage (EX/MEM outputs) and register-file writeback, driving a variable-latency data memory through a req/ack handshake. Stalls upstream while an access is outstanding and propagates halt. Its `wb_*` outputs are the retirement signals the CPU testbench traces.

---
 rtl/mem_wb_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB register: issues req/ack data-memory accesses, stalls upstream, retires to wb_*.
// Optional WAIT timeout (mem_err, wb_data=0xDEAD) is compiled in when MEM_WB_TIMEOUT_EN is defined.
module mem_wb_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_halt,
  input  logic [REG_W-1:0]  ex_wr_reg,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [DATA_W-1:0] ex_pc,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_halt,
  output logic [REG_W-1:0]  wb_wr_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] wb_pc,
  output logic [DATA_W-1:0] wb_mem_addr,
  output logic              hlt,
  output logic [15:0]       stall_cycles,
  output logic              mem_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HALTED = 2'd2} state_t;

  state_t             state;
  logic               h_reg_write;
  logic [REG_W-1:0]   h_wr_reg;
  logic [DATA_W-1:0]  h_pc;
  logic               is_mem;
  logic               accept_mem;
  logic               timeout_hit;

  // A halt wins over any memory bits it carries, so it never opens an access.
  assign is_mem     = ex_valid & ~ex_halt & (ex_mem_read | ex_mem_write);
  assign accept_mem = (state == IDLE) & is_mem;
  assign dbg_state  = state;

`ifdef MEM_WB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt;
  logic       err_q;
  assign timeout_hit = (state == WAIT) & ~dmem_ack & (tmo_cnt == TMO_LAST);
  assign mem_err     = err_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  // The timeout cycle releases the stall so upstream drops the failed op instead of re-issuing it.
  assign mem_stall = accept_mem
                   | ((state == WAIT) & ~dmem_ack & ~timeout_hit)
                   | (state == HALTED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      h_reg_write  <= 1'b0;
      h_wr_reg     <= '0;
      h_pc         <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_halt      <= 1'b0;
      wb_wr_reg    <= '0;
      wb_data      <= '0;
      wb_pc        <= '0;
      wb_mem_addr  <= '0;
      hlt          <= 1'b0;
      stall_cycles <= '0;
`ifdef MEM_WB_TIMEOUT_EN
      tmo_cnt      <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      if (mem_stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_halt      <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid && ex_halt) begin
            wb_valid    <= 1'b1;
            wb_halt     <= 1'b1;
            wb_wr_reg   <= ex_wr_reg;
            wb_data     <= ex_alu_result;
            wb_pc       <= ex_pc;
            wb_mem_addr <= '0;
            hlt         <= 1'b1;
            state       <= HALTED;
          end else if (is_mem) begin
            dmem_req    <= 1'b1;
            dmem_we     <= ex_mem_write & ~ex_mem_read;
            dmem_addr   <= ex_alu_result;
            dmem_wdata  <= ex_store_data;
            h_reg_write <= ex_reg_write;
            h_wr_reg    <= ex_wr_reg;
            h_pc        <= ex_pc;
`ifdef MEM_WB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
            state       <= WAIT;
          end else if (ex_valid) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= ex_reg_write;
            wb_wr_reg    <= ex_wr_reg;
            wb_data      <= ex_alu_result;
            wb_pc        <= ex_pc;
            wb_mem_addr  <= '0;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= h_reg_write & ~dmem_we;
            wb_wr_reg    <= h_wr_reg;
            wb_data      <= dmem_we ? dmem_addr : dmem_rdata;
            wb_pc        <= h_pc;
            wb_mem_addr  <= dmem_addr;
            state        <= IDLE;
          end
`ifdef MEM_WB_TIMEOUT_EN
          else if (timeout_hit) begin
            err_q       <= 1'b1;
            dmem_req    <= 1'b0;
            wb_valid    <= 1'b1;
            wb_wr_reg   <= h_wr_reg;
            wb_data     <= DATA_W'(16'hDEAD);
            wb_pc       <= h_pc;
            wb_mem_addr <= dmem_addr;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: drivers push expected retirements, a negedge monitor pops and compares.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_halt;
  logic [3:0]  ex_wr_reg;
  logic [15:0] ex_alu_result, ex_store_data, ex_pc;
  logic        mem_stall, dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic        wb_valid, wb_reg_write, wb_halt;
  logic [3:0]  wb_wr_reg;
  logic [15:0] wb_data, wb_pc, wb_mem_addr;
  logic        hlt;
  logic [15:0] stall_cycles;
  logic        mem_err;
  logic [1:0]  dbg_state;

  logic [53:0] exp_q[$];
  logic [53:0] exp_e;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          exp_stall = 0;

  mem_wb_stage #(.DATA_W(16), .REG_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_halt(ex_halt), .ex_wr_reg(ex_wr_reg),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_halt(wb_halt),
    .wb_wr_reg(wb_wr_reg), .wb_data(wb_data), .wb_pc(wb_pc), .wb_mem_addr(wb_mem_addr),
    .hlt(hlt), .stall_cycles(stall_cycles), .mem_err(mem_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [53:0] wb_pack(input logic h, input logic rw, input logic [3:0] r,
                                          input logic [15:0] d, input logic [15:0] pc,
                                          input logic [15:0] ma);
    return {h, rw, r, d, pc, ma};
  endfunction

  // scoreboard monitor: wb outputs are registered, so they are stable at the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (exp_q.size() == 0) check("wb_unexpected", 1, 0);
        else begin
          exp_e = exp_q.pop_front();
          check("wb", {wb_halt, wb_reg_write, wb_wr_reg, wb_data, wb_pc, wb_mem_addr}, exp_e);
        end
      end
    end
  end

  task automatic clear_ex();
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_halt = 0;
    ex_wr_reg = 0; ex_alu_result = 0; ex_store_data = 0; ex_pc = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; dmem_ack = 0; dmem_rdata = 0;
    clear_ex();
    repeat (2) @(negedge clk);
    #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_hlt", hlt, 0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_state", dbg_state, 0);
    check("rst_wb_data", wb_data, 0);
    rst_n = 1;
    exp_stall = 0;
  endtask

  task automatic idle_cycle();
    clear_ex();
    @(negedge clk);
  endtask

  task automatic alu_op(input logic rw, input logic [3:0] r, input logic [15:0] d, input logic [15:0] pc);
    ex_valid = 1; ex_mem_read = 0; ex_mem_write = 0; ex_halt = 0;
    ex_reg_write = rw; ex_wr_reg = r; ex_alu_result = d; ex_store_data = 16'($urandom); ex_pc = pc;
    #1 check("alu_stall", mem_stall, 0);
    exp_q.push_back(wb_pack(1'b0, rw, r, d, pc, 16'h0));
    @(negedge clk);
  endtask

  task automatic mem_op(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [3:0] r, input logic rw, input logic [15:0] pc,
                        input int k, input logic [15:0] rdata);
    logic is_read;
    is_read = rd;
    ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_halt = 0;
    ex_reg_write = rw; ex_wr_reg = r; ex_alu_result = addr; ex_store_data = wdata; ex_pc = pc;
    #1 check("accept_stall", mem_stall, 1);
    exp_stall++;
    exp_q.push_back(wb_pack(1'b0, is_read ? rw : 1'b0, r, is_read ? rdata : addr, pc, addr));
    @(negedge clk);
    for (int i = 1; i <= k; i++) begin
      if (i == k) begin dmem_ack = 1; dmem_rdata = rdata; end
      else dmem_rdata = 16'($urandom);
      #1;
      check("wait_req", dmem_req, 1);
      check("wait_addr", dmem_addr, addr);
      check("wait_we", dmem_we, !is_read);
      if (!is_read) check("wait_wdata", dmem_wdata, wdata);
      check("wait_stall", mem_stall, (i != k));
      if (i != k) exp_stall++;
      @(negedge clk);
      dmem_ack = 0;
    end
    check("stall_cnt", stall_cycles, exp_stall);
  endtask

  initial begin
    do_reset();

    // ALU op retires next cycle
    alu_op(1'b1, 4'd3, 16'h1234, 16'h0010);
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_wr_reg", wb_wr_reg, 3);
    check("alu_wb_data", wb_data, 16'h1234);
    check("alu_wb_mem_addr", wb_mem_addr, 0);

    // load with 3-cycle ack
    mem_op(1'b1, 1'b0, 16'h0040, 16'h0, 4'd7, 1'b1, 16'h0012, 3, 16'hBEEF);
    check("ld_wb_data", wb_data, 16'hBEEF);
    check("ld_wb_mem_addr", wb_mem_addr, 16'h0040);
    check("ld_stall_cycles", stall_cycles, 3);

    // store then load back-to-back, ack latency 1
    mem_op(1'b0, 1'b1, 16'h0020, 16'h0055, 4'd2, 1'b1, 16'h0014, 1, 16'h0);
    check("st_wb_reg_write", wb_reg_write, 0);
    mem_op(1'b1, 1'b0, 16'h0020, 16'h0, 4'd4, 1'b1, 16'h0016, 1, 16'h0055);
    check("b2b_stall_cycles", stall_cycles, 5);

    // read+write together behaves as a read
    mem_op(1'b1, 1'b1, 16'h0080, 16'h1111, 4'd9, 1'b1, 16'h0018, 2, 16'hCAFE);
    idle_cycle();

    // random mix
    for (int n = 0; n < 16; n++) begin
      int kind;
      kind = $urandom_range(2, 0);
      if (kind == 0)
        alu_op(1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
      else if (kind == 1)
        mem_op(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
               16'($urandom), $urandom_range(4, 1), 16'($urandom));
      else
        mem_op(1'b0, 1'b1, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
               16'($urandom), $urandom_range(4, 1), 16'($urandom));
      if ($urandom_range(1, 0) == 1) idle_cycle();
    end
    idle_cycle();

    // reset in the middle of WAIT abandons the access; a stray ack is ignored
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_alu_result = 16'h0099; ex_wr_reg = 4'd1;
    ex_reg_write = 1; ex_halt = 0; ex_pc = 16'h0100;
    repeat (3) @(negedge clk);
    #1 check("midwait_req", dmem_req, 1);
    do_reset();
    dmem_ack = 1; dmem_rdata = 16'h5A5A;
    @(negedge clk);
    dmem_ack = 0;
    #1 check("stray_ack_wb_valid", wb_valid, 0);
    @(negedge clk);
    #1 check("stray_ack_req", dmem_req, 0);

    // halt after an ALU op
    alu_op(1'b1, 4'd6, 16'h00AA, 16'h0200);
    ex_valid = 1; ex_halt = 1; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0;
    ex_wr_reg = 4'd5; ex_alu_result = 16'h0077; ex_pc = 16'h0202;
    #1 check("halt_present_stall", mem_stall, 0);
    exp_q.push_back(wb_pack(1'b1, 1'b0, 4'd5, 16'h0077, 16'h0202, 16'h0));
    @(negedge clk);
    #1;
    check("halt_wb_halt", wb_halt, 1);
    check("halt_hlt", hlt, 1);
    check("halt_state", dbg_state, 2);
    for (int n = 0; n < 5; n++) begin
      ex_valid = 1; ex_halt = 0; ex_reg_write = 1; ex_mem_read = 1'($urandom);
      ex_alu_result = 16'($urandom);
      #1 check("halted_stall", mem_stall, 1);
      exp_stall++;
      @(negedge clk);
    end
    check("halted_stall_cycles", stall_cycles, exp_stall);
    check("halted_hlt_sticky", hlt, 1);

`ifdef MEM_WB_TIMEOUT_EN
    // no ack: timeout after 4 WAIT cycles
    do_reset();
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_reg_write = 1; ex_halt = 0;
    ex_wr_reg = 4'd2; ex_alu_result = 16'h0033; ex_pc = 16'h0040;
    #1 check("tmo_accept_stall", mem_stall, 1);
    exp_q.push_back(wb_pack(1'b0, 1'b0, 4'd2, 16'hDEAD, 16'h0040, 16'h0033));
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      #1 check("tmo_req", dmem_req, 1);
      check("tmo_err_early", mem_err, 0);
      @(negedge clk);
    end
    clear_ex();
    #1;
    check("tmo_mem_err", mem_err, 1);
    check("tmo_wb_data", wb_data, 16'hDEAD);
    check("tmo_state", dbg_state, 0);
    check("tmo_req_dropped", dmem_req, 0);
    @(negedge clk);
    #1 check("tmo_err_sticky", mem_err, 1);
`endif

    clear_ex();
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
